// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side control blocks: word width, pipeline depth and
// the PC sequencer state set.
package cpu_pkg;

    localparam int WORD_W     = 32;
    localparam int PIPE_DEPTH = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer above the pipelined core: PC register, stall watchdog,
// end-of-program drain and performance counters.
//
//  state | meaning
//  IDLE  | after reset, pc parked at RESET_PC, waiting for start
//  RUN   | fetching; pc follows next_addr whenever pc_write=1
//  DRAIN | last fetch issued, waiting DRAIN_CYCLES clocks for the pipe to empty
//  DONE  | program finished, counters frozen, start re-runs
//  ERROR | watchdog or misaligned next_addr, sticky until start or rst
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [WORD_W-1:0] END_PC       = 32'h0000_0100,
    parameter int                DRAIN_CYCLES = PIPE_DEPTH - 1,
    parameter int                STALL_LIMIT  = 8,
    parameter int                CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] next_addr,
    input  logic              pc_write,
    output logic [WORD_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_RUN   = RUN;
    localparam logic [2:0] ST_DRAIN = DRAIN;
    localparam logic [2:0] ST_DONE  = DONE;
    localparam logic [2:0] ST_ERROR = ERROR;

    localparam int                DRAIN_W    = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam int                STALL_W    = $clog2(STALL_LIMIT) + 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    logic [2:0]         state;
    logic [DRAIN_W-1:0] drain_tmr;
    logic [STALL_W-1:0] stall_run;

    logic in_run;
    logic in_drain;
    logic launch;
    logic misaligned;
    logic advance;
    logic stalled;

    assign in_run     = (state == ST_RUN);
    assign in_drain   = (state == ST_DRAIN);
    assign launch     = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign misaligned = (next_addr[1:0] != 2'b00);
    assign advance    = in_run && pc_write && !misaligned;
    assign stalled    = in_run && !pc_write;

    assign busy  = in_run || in_drain;
    assign done  = (state == ST_DONE);
    assign error = (state == ST_ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            drain_tmr <= '0;
            stall_run <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        pc        <= RESET_PC;
                        stall_run <= '0;
                        drain_tmr <= DRAIN_LOAD;
                        // An empty program has nothing to fetch and goes straight to drain.
                        state     <= (END_PC == RESET_PC) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pc_write) begin
                        if (misaligned) begin
                            state <= ST_ERROR;
                        end else begin
                            pc        <= next_addr;
                            stall_run <= '0;
                            if (next_addr == END_PC) begin
                                drain_tmr <= DRAIN_LOAD;
                                state     <= ST_DRAIN;
                            end
                        end
                    end else begin
                        stall_run <= stall_run + 1'b1;
                        if (stall_run == STALL_LAST) begin
                            state <= ST_ERROR;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_tmr == '0) begin
                        state <= ST_DONE;
                    end else begin
                        drain_tmr <= drain_tmr - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .inc   (in_run || in_drain),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .inc   (stalled),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .inc   (advance),
        .count (fetch_cnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a cycle model,
// and a second instance covering the empty-program and counter-saturation corners.
module tb_pc_sequencer;

    localparam logic [31:0] END_A    = 32'h0000_0040;
    localparam int          LIMIT    = 8;
    localparam int          DRAIN_A  = 4;
    localparam logic [31:0] PC_B     = 32'h0000_0080;
    localparam int          DRAIN_B  = 12;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pc_write;
    logic [31:0] next_addr;
    logic [31:0] pc;
    logic        busy, done, error;
    logic [31:0] cycle_cnt, stall_cnt, fetch_cnt;

    logic        b_start;
    logic        b_pc_write;
    logic [31:0] b_next_addr;
    logic [31:0] b_pc;
    logic        b_busy, b_done, b_error;
    logic [2:0]  b_cycle_cnt, b_stall_cnt, b_fetch_cnt;

    int total = 0;
    int bad   = 0;

    // reference model: mode 0 idle, 1 run, 2 drain, 3 done, 4 error
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cyc, m_stl, m_fch;
    int          m_consec;
    int          m_drain_left;

    pc_sequencer #(
        .RESET_PC     (32'h0000_0000),
        .END_PC       (END_A),
        .DRAIN_CYCLES (DRAIN_A),
        .STALL_LIMIT  (LIMIT),
        .CNT_W        (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .next_addr (next_addr),
        .pc_write  (pc_write),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cycle_cnt (cycle_cnt),
        .stall_cnt (stall_cnt),
        .fetch_cnt (fetch_cnt)
    );

    pc_sequencer #(
        .RESET_PC     (PC_B),
        .END_PC       (PC_B),
        .DRAIN_CYCLES (DRAIN_B),
        .STALL_LIMIT  (LIMIT),
        .CNT_W        (3)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (b_start),
        .next_addr (b_next_addr),
        .pc_write  (b_pc_write),
        .pc        (b_pc),
        .busy      (b_busy),
        .done      (b_done),
        .error     (b_error),
        .cycle_cnt (b_cycle_cnt),
        .stall_cnt (b_stall_cnt),
        .fetch_cnt (b_fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_mode       = 0;
        m_pc         = 32'h0;
        m_cyc        = 0;
        m_stl        = 0;
        m_fch        = 0;
        m_consec     = 0;
        m_drain_left = 0;
    endtask

    task automatic model_step();
        case (m_mode)
            0, 3, 4: begin
                if (start) begin
                    m_pc         = 32'h0;
                    m_cyc        = 0;
                    m_stl        = 0;
                    m_fch        = 0;
                    m_consec     = 0;
                    m_drain_left = DRAIN_A;
                    m_mode       = 1;
                end
            end
            1: begin
                m_cyc = sat_inc(m_cyc);
                if (pc_write) begin
                    if (next_addr % 4 != 0) begin
                        m_mode = 4;
                    end else begin
                        m_pc     = next_addr;
                        m_fch    = sat_inc(m_fch);
                        m_consec = 0;
                        if (next_addr == END_A) begin
                            m_mode       = 2;
                            m_drain_left = DRAIN_A;
                        end
                    end
                end else begin
                    m_stl    = sat_inc(m_stl);
                    m_consec = m_consec + 1;
                    if (m_consec >= LIMIT) m_mode = 4;
                end
            end
            2: begin
                m_cyc        = sat_inc(m_cyc);
                m_drain_left = m_drain_left - 1;
                if (m_drain_left == 0) m_mode = 3;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc,        m_pc);
        chk({tag, ".busy"},  busy,      (m_mode == 1 || m_mode == 2));
        chk({tag, ".done"},  done,      (m_mode == 3));
        chk({tag, ".error"}, error,     (m_mode == 4));
        chk({tag, ".cyc"},   cycle_cnt, m_cyc);
        chk({tag, ".stl"},   stall_cnt, m_stl);
        chk({tag, ".fch"},   fetch_cnt, m_fch);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        pc_write    = 1'b0;
        next_addr   = 32'h0;
        b_start     = 1'b0;
        b_pc_write  = 1'b1;
        b_next_addr = PC_B + 32'd4;
        model_reset();
        #12;
        check_all("reset");
        chk("reset_b.pc", b_pc, PC_B);
        rst = 1'b0;
        #1;

        // full program run to END_PC, then drain
        start = 1'b1;
        tick("t2_start");
        start    = 1'b0;
        pc_write = 1'b1;
        for (int i = 0; i < 16 + DRAIN_A; i++) begin
            next_addr = m_pc + 32'd4;
            tick("t2_run");
        end
        chk("t2_done",  done,      1'b1);
        chk("t2_pc",    pc,        END_A);
        chk("t2_fetch", fetch_cnt, 32'd16);
        chk("t2_cycle", cycle_cnt, 32'd20);

        // restart from DONE
        start = 1'b1;
        tick("t6_restart");
        start = 1'b0;
        chk("t6_pc",   pc,        32'h0);
        chk("t6_cyc",  cycle_cnt, 32'd0);
        chk("t6_fch",  fetch_cnt, 32'd0);
        chk("t6_done", done,      1'b0);

        // short stall at pc=8, start during RUN ignored
        for (int i = 0; i < 2; i++) begin
            next_addr = m_pc + 32'd4;
            tick("t3_adv");
        end
        pc_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            tick("t3_stall");
        end
        start = 1'b0;
        chk("t3_pc_hold", pc,        32'h8);
        chk("t3_stl",     stall_cnt, 32'd3);
        chk("t3_err",     error,     1'b0);
        pc_write  = 1'b1;
        next_addr = 32'hC;
        tick("t3_resume");
        chk("t3_pc_adv", pc, 32'hC);

        // watchdog
        pc_write = 1'b0;
        for (int i = 0; i < LIMIT - 1; i++) tick("t4_stall");
        chk("t4_no_err", error, 1'b0);
        tick("t4_trip");
        chk("t4_err",  error, 1'b1);
        chk("t4_busy", busy,  1'b0);
        start = 1'b1;
        tick("t4_restart");
        start = 1'b0;
        chk("t4_err_clr", error, 1'b0);
        chk("t4_pc",      pc,    32'h0);

        // misaligned next_addr
        pc_write  = 1'b1;
        next_addr = 32'h4;
        tick("t5_adv");
        next_addr = 32'h6;
        tick("t5_mis");
        chk("t5_err", error, 1'b1);
        chk("t5_pc",  pc,    32'h4);

        // async reset mid-run at pc=0x20
        start = 1'b1;
        tick("t1_start");
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            next_addr = m_pc + 32'd4;
            tick("t1_adv");
        end
        chk("t1_pre_pc", pc, 32'h20);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t1_pc",   pc,        32'h0);
        chk("t1_busy", busy,      1'b0);
        chk("t1_cyc",  cycle_cnt, 32'd0);
        chk("t1_fch",  fetch_cnt, 32'd0);
        check_all("t1_async");
        #1;
        rst = 1'b0;

        // random traffic in three stall-density phases
        for (int ph = 0; ph < 3; ph++) begin
            int stall_pct;
            stall_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : 93;
            for (int i = 0; i < 250; i++) begin
                int r;
                if (m_mode == 1 || m_mode == 2) start = ($urandom_range(0, 49) == 0);
                else                            start = ($urandom_range(0, 3) == 0);
                pc_write = ($urandom_range(0, 99) >= stall_pct);
                r = $urandom_range(0, 39);
                if (r == 0)      next_addr = m_pc + 32'd2;
                else if (r == 1) next_addr = 32'($urandom_range(0, 15)) * 32'd4;
                else             next_addr = m_pc + 32'd4;
                tick("rnd");
            end
        end
        start    = 1'b0;
        pc_write = 1'b0;

        // empty program with saturating 3-bit counters
        b_start = 1'b1;
        tick("b_start");
        b_start = 1'b0;
        chk("b_busy0", b_busy,      1'b1);
        chk("b_cyc0",  b_cycle_cnt, 3'd0);
        for (int k = 1; k <= DRAIN_B; k++) begin
            tick("b_idle_main");
            chk("b_done",  b_done,      (k >= DRAIN_B));
            chk("b_cyc",   b_cycle_cnt, (k > 7) ? 3'd7 : 3'(k));
            chk("b_fch",   b_fetch_cnt, 3'd0);
            chk("b_pc",    b_pc,        PC_B);
            chk("b_err",   b_error,     1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
